pq_shift_array: RTL and testbench

// - Parametrised register-array (systolic shift) hardware priority queue; device side of the standard HWPQ handshake.
// - Holds up to PQ_CAPACITY <key,value> entries sorted by key, with the highest-priority entry always presented on odata.
// - Adds what a bare queue lacks:
//   - selectable min/max ordering
//   - FIFO tie-break among equal keys
//   - single-cycle replace-top (push+pop) when full
//   - synchronous flush

---
 rtl/pq_shift_array.sv | 158 +++++++++++++++
 tb/tb_pq_shift_array.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pq_shift_array.sv
// Systolic shift-register priority queue: sorted <key,value> slots, head always on odata.
// Optional PQ_HIWATER_EN adds a hiwater output tracking peak occupancy since reset/flush.
module pq_shift_array #(
    parameter int KEY_WIDTH   = 4,
    parameter int VAL_WIDTH   = 4,
    parameter int PQ_CAPACITY = 4,
    parameter bit MAX_FIRST   = 1'b1,
    localparam int KV_W = KEY_WIDTH + VAL_WIDTH,
    localparam int CW   = $clog2(PQ_CAPACITY + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ivalid,
    output logic            irdy,
    input  logic [KV_W-1:0] idata,
    input  logic            flush,
    output logic            busy,
    output logic            full,
    output logic [CW-1:0]   count,
    output logic            ovalid,
    input  logic            ordy,
`ifdef PQ_HIWATER_EN
    output logic [CW-1:0]   hiwater,
`endif
    output logic [KV_W-1:0] odata
);

    logic [KV_W-1:0]        ent_p0 [PQ_CAPACITY];
    logic [PQ_CAPACITY-1:0] vld_p0;
    logic [CW-1:0]          count_p0;

    logic                   push;
    logic                   pop;
    logic [KV_W-1:0]        base [PQ_CAPACITY];
    logic [PQ_CAPACITY-1:0] base_v;
    logic [KV_W-1:0]        shft [PQ_CAPACITY];
    logic [PQ_CAPACITY-1:0] shft_v;
    logic [PQ_CAPACITY-1:0] ge;
    logic [PQ_CAPACITY-1:0] ins;
    logic [KV_W-1:0]        ent_nxt [PQ_CAPACITY];
    logic [PQ_CAPACITY-1:0] vld_nxt;
    logic [CW-1:0]          count_nxt;

    // True when an existing slot key stays ahead of an incoming key (ties keep arrival order).
    function automatic logic ahead_or_tie(input logic [KEY_WIDTH-1:0] slot_key,
                                          input logic [KEY_WIDTH-1:0] new_key);
        if (MAX_FIRST)
            return slot_key >= new_key;
        else
            return slot_key <= new_key;
    endfunction

    assign full   = (count_p0 == CW'(PQ_CAPACITY));
    assign count  = count_p0;
    assign ovalid = vld_p0[0];
    assign busy   = vld_p0[0];
    assign odata  = ent_p0[0];
    assign irdy   = !flush && (!full || ordy);
    assign push   = ivalid && irdy;
    assign pop    = vld_p0[0] && ordy && !flush;

    always_comb begin
        for (int i = 0; i < PQ_CAPACITY; i++) begin
            base[i]    = '0;
            shft[i]    = '0;
            ent_nxt[i] = '0;
        end
        base_v    = '0;
        shft_v    = '0;
        ge        = '0;
        ins       = '0;
        vld_nxt   = '0;
        count_nxt = count_p0;

        // Head removal: everything moves one slot toward the head, tail empties.
        for (int i = 0; i < PQ_CAPACITY; i++) begin
            base[i]   = ent_p0[i];
            base_v[i] = vld_p0[i];
        end
        if (pop) begin
            for (int i = 0; i < PQ_CAPACITY - 1; i++) begin
                base[i]   = ent_p0[i+1];
                base_v[i] = vld_p0[i+1];
            end
            base[PQ_CAPACITY-1]   = '0;
            base_v[PQ_CAPACITY-1] = 1'b0;
        end

        for (int i = 1; i < PQ_CAPACITY; i++) begin
            shft[i]   = base[i-1];
            shft_v[i] = base_v[i-1];
        end

        // Slots are sorted, so ge is a thermometer; its first zero is the insertion point.
        for (int i = 0; i < PQ_CAPACITY; i++)
            ge[i] = base_v[i] && ahead_or_tie(base[i][KV_W-1 -: KEY_WIDTH],
                                              idata[KV_W-1 -: KEY_WIDTH]);
        ins[0] = !ge[0];
        for (int i = 1; i < PQ_CAPACITY; i++)
            ins[i] = !ge[i] && ge[i-1];

        for (int i = 0; i < PQ_CAPACITY; i++) begin
            if (!push || ge[i]) begin
                ent_nxt[i] = base[i];
                vld_nxt[i] = base_v[i];
            end else if (ins[i]) begin
                ent_nxt[i] = idata;
                vld_nxt[i] = 1'b1;
            end else begin
                ent_nxt[i] = shft[i];
                vld_nxt[i] = shft_v[i];
            end
        end

        if (push && !pop)
            count_nxt = count_p0 + CW'(1);
        else if (pop && !push)
            count_nxt = count_p0 - CW'(1);

        if (flush) begin
            for (int i = 0; i < PQ_CAPACITY; i++)
                ent_nxt[i] = '0;
            vld_nxt   = '0;
            count_nxt = '0;
        end
    end

    // Slot register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PQ_CAPACITY; i++)
                ent_p0[i] <= '0;
            vld_p0   <= '0;
            count_p0 <= '0;
        end else begin
            for (int i = 0; i < PQ_CAPACITY; i++)
                ent_p0[i] <= ent_nxt[i];
            vld_p0   <= vld_nxt;
            count_p0 <= count_nxt;
        end
    end

`ifdef PQ_HIWATER_EN
    logic [CW-1:0] hiwater_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hiwater_p0 <= '0;
        else if (flush)
            hiwater_p0 <= '0;
        else if (count_nxt > hiwater_p0)
            hiwater_p0 <= count_nxt;
    end

    assign hiwater = hiwater_p0;
`endif

endmodule

// File: tb/tb_pq_shift_array.sv
// Directed vector bench for pq_shift_array: max-first instance via a cycle table,
// min-first instance and asynchronous reset via short hand-written sequences.
module tb_pq_shift_array;

    logic       clk = 1'b0;
    logic       rst;

    logic       ivalid, irdy, flush, busy, full, ovalid, ordy;
    logic [7:0] idata, odata;
    logic [2:0] count;

    logic       m_ivalid, m_irdy, m_flush, m_busy, m_full, m_ovalid, m_ordy;
    logic [7:0] m_idata, m_odata;
    logic [2:0] m_count;
`ifdef PQ_HIWATER_EN
    logic [2:0] hiwater, m_hiwater;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pq_shift_array #(.KEY_WIDTH(4), .VAL_WIDTH(4), .PQ_CAPACITY(4), .MAX_FIRST(1'b1)) u_max (
        .clk(clk), .rst(rst), .ivalid(ivalid), .irdy(irdy), .idata(idata), .flush(flush),
        .busy(busy), .full(full), .count(count), .ovalid(ovalid), .ordy(ordy),
`ifdef PQ_HIWATER_EN
        .hiwater(hiwater),
`endif
        .odata(odata));

    pq_shift_array #(.KEY_WIDTH(4), .VAL_WIDTH(4), .PQ_CAPACITY(4), .MAX_FIRST(1'b0)) u_min (
        .clk(clk), .rst(rst), .ivalid(m_ivalid), .irdy(m_irdy), .idata(m_idata), .flush(m_flush),
        .busy(m_busy), .full(m_full), .count(m_count), .ovalid(m_ovalid), .ordy(m_ordy),
`ifdef PQ_HIWATER_EN
        .hiwater(m_hiwater),
`endif
        .odata(m_odata));

    typedef struct {
        int iv; int id; int rd; int fl;
        int e_irdy; int e_ov; int e_od; int e_cnt; int e_full; int e_hw;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // Expected values are the pre-edge outputs in the cycle the inputs are applied.
        tbl[0]  = '{1, 'h31, 0, 0, 1, 0, 'h00, 0, 0, 0};
        tbl[1]  = '{1, 'h9A, 0, 0, 1, 1, 'h31, 1, 0, 1};
        tbl[2]  = '{1, 'h12, 0, 0, 1, 1, 'h9A, 2, 0, 2};
        tbl[3]  = '{1, 'h9B, 0, 0, 1, 1, 'h9A, 3, 0, 3};
        tbl[4]  = '{0, 'h00, 0, 0, 0, 1, 'h9A, 4, 1, 4};
        tbl[5]  = '{1, 'h5C, 0, 0, 0, 1, 'h9A, 4, 1, 4};
        tbl[6]  = '{0, 'h00, 0, 0, 0, 1, 'h9A, 4, 1, 4};
        tbl[7]  = '{1, 'h5C, 1, 0, 1, 1, 'h9A, 4, 1, 4};
        tbl[8]  = '{0, 'h00, 1, 0, 1, 1, 'h9B, 4, 1, 4};
        tbl[9]  = '{0, 'h00, 1, 0, 1, 1, 'h5C, 3, 0, 4};
        tbl[10] = '{0, 'h00, 1, 0, 1, 1, 'h31, 2, 0, 4};
        tbl[11] = '{0, 'h00, 1, 0, 1, 1, 'h12, 1, 0, 4};
        tbl[12] = '{0, 'h00, 0, 0, 1, 0, 'h00, 0, 0, 4};
        tbl[13] = '{1, 'h77, 1, 0, 1, 0, 'h00, 0, 0, 4};
        tbl[14] = '{0, 'h00, 1, 0, 1, 1, 'h77, 1, 0, 4};
        tbl[15] = '{0, 'h00, 0, 0, 1, 0, 'h00, 0, 0, 4};
        tbl[16] = '{1, 'h21, 0, 0, 1, 0, 'h00, 0, 0, 4};
        tbl[17] = '{1, 'h42, 0, 0, 1, 1, 'h21, 1, 0, 4};
        tbl[18] = '{1, 'h63, 0, 0, 1, 1, 'h42, 2, 0, 4};
        tbl[19] = '{1, 'h88, 1, 1, 0, 1, 'h63, 3, 0, 4};
        tbl[20] = '{0, 'h00, 0, 0, 1, 0, 'h00, 0, 0, 0};
        tbl[21] = '{0, 'h00, 1, 0, 1, 0, 'h00, 0, 0, 0};
        tbl[22] = '{0, 'h00, 0, 0, 1, 0, 'h00, 0, 0, 0};

        rst = 1'b1;
        ivalid = 1'b0; idata = 8'h00; flush = 1'b0; ordy = 1'b0;
        m_ivalid = 1'b0; m_idata = 8'h00; m_flush = 1'b0; m_ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_ovalid", int'(ovalid), 0);
        chk("reset_odata", int'(odata), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_irdy", int'(irdy), 1);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            ivalid = 1'(tbl[i].iv);
            idata  = 8'(tbl[i].id);
            ordy   = 1'(tbl[i].rd);
            flush  = 1'(tbl[i].fl);
            #1;
            chk($sformatf("v%0d_irdy", i), int'(irdy), tbl[i].e_irdy);
            chk($sformatf("v%0d_ovalid", i), int'(ovalid), tbl[i].e_ov);
            chk($sformatf("v%0d_busy", i), int'(busy), tbl[i].e_ov);
            chk($sformatf("v%0d_odata", i), int'(odata), tbl[i].e_od);
            chk($sformatf("v%0d_count", i), int'(count), tbl[i].e_cnt);
            chk($sformatf("v%0d_full", i), int'(full), tbl[i].e_full);
`ifdef PQ_HIWATER_EN
            chk($sformatf("v%0d_hiwater", i), int'(hiwater), tbl[i].e_hw);
`endif
        end
        @(negedge clk);
        ivalid = 1'b0; ordy = 1'b0; flush = 1'b0;

        // Min-first ordering: keys 3,9,1 must come out 1,3,9.
        begin
            int keys [3] = '{3, 9, 1};
            int pops [3] = '{1, 3, 9};
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                m_ivalid = 1'b1;
                m_idata  = 8'(keys[k] * 16 + k);
            end
            @(negedge clk);
            m_ivalid = 1'b0;
            #1;
            chk("min_count", int'(m_count), 3);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                m_ordy = 1'b1;
                #1;
                chk($sformatf("min_pop%0d_key", k), int'(m_odata[7:4]), pops[k]);
            end
            @(negedge clk);
            m_ordy = 1'b0;
            #1;
            chk("min_empty_ovalid", int'(m_ovalid), 0);
`ifdef PQ_HIWATER_EN
            chk("min_hiwater", int'(m_hiwater), 3);
`endif
        end

        // Asynchronous reset between clock edges while full.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ivalid = 1'b1;
            idata  = 8'(8'h40 + k);
        end
        @(negedge clk);
        ivalid = 1'b0;
        #1;
        chk("pre_rst_full", int'(full), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_ovalid", int'(ovalid), 0);
        chk("async_rst_full", int'(full), 0);
        chk("async_rst_odata", int'(odata), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_irdy", int'(irdy), 1);
        chk("post_rst_count", int'(count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
